mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 124 ++++++++++++
 rtl/mc_controller_if.sv | 40 ++++
 rtl/mc_controller_mainfsm.sv | 63 ++++++
 rtl/mc_controller.sv | 154 +++++++++++++++
 tb/tb_mc_controller.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_pkg
// Description : Shared types and codes for the multicycle controller: FSM
//               state enumeration, ALUControl codes, ALU-B and result mux
//               selects, data-processing command codes, condition codes and
//               the per-state control-word lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_ORR = 3'b011;
  localparam logic [2:0] C_ALU_EOR = 3'b100;

  localparam logic [1:0] C_SRCB_REG  = 2'b00;
  localparam logic [1:0] C_SRCB_EXT  = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR = 2'b10;

  localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
  localparam logic [1:0] C_RES_DATA      = 2'b01;
  localparam logic [1:0] C_RES_ALURESULT = 2'b10;

  // Funct[4:1] command field of data-processing instructions
  localparam logic [3:0] C_CMD_ADD = 4'b0100;
  localparam logic [3:0] C_CMD_SUB = 4'b0010;
  localparam logic [3:0] C_CMD_AND = 4'b0000;
  localparam logic [3:0] C_CMD_ORR = 4'b1100;
  localparam logic [3:0] C_CMD_EOR = 4'b0001;

  localparam logic [3:0] C_COND_EQ = 4'h0;
  localparam logic [3:0] C_COND_NE = 4'h1;
  localparam logic [3:0] C_COND_CS = 4'h2;
  localparam logic [3:0] C_COND_CC = 4'h3;
  localparam logic [3:0] C_COND_MI = 4'h4;
  localparam logic [3:0] C_COND_PL = 4'h5;
  localparam logic [3:0] C_COND_VS = 4'h6;
  localparam logic [3:0] C_COND_VC = 4'h7;
  localparam logic [3:0] C_COND_HI = 4'h8;
  localparam logic [3:0] C_COND_LS = 4'h9;
  localparam logic [3:0] C_COND_GE = 4'hA;
  localparam logic [3:0] C_COND_LT = 4'hB;
  localparam logic [3:0] C_COND_GT = 4'hC;
  localparam logic [3:0] C_COND_LE = 4'hD;
  localparam logic [3:0] C_COND_AL = 4'hE;

  // Unconditioned control word produced by the main FSM for each state
  typedef struct packed {
    logic       regw;
    logic       memw;
    logic       pcs;
    logic       branch;
    logic       irwrite;
    logic       nextpc;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite   = 1'b1;
        c.nextpc    = 1'b1;
        c.alusrca   = 1'b1;
        c.alusrcb   = C_SRCB_FOUR;
        c.resultsrc = C_RES_ALURESULT;
      end
      S_DECODE: begin
        c.alusrca   = 1'b1;
        c.alusrcb   = C_SRCB_FOUR;
        c.resultsrc = C_RES_ALURESULT;
      end
      S_MEMADR:   c.alusrcb = C_SRCB_EXT;
      S_MEMREAD: begin
        c.adrsrc    = 1'b1;
        c.resultsrc = C_RES_ALUOUT;
      end
      S_MEMWB: begin
        c.resultsrc = C_RES_DATA;
        c.regw      = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc    = 1'b1;
        c.resultsrc = C_RES_ALUOUT;
        c.memw      = 1'b1;
      end
      S_EXECUTER: c.alusrcb = C_SRCB_REG;
      S_EXECUTEI: c.alusrcb = C_SRCB_EXT;
      S_ALUWB: begin
        c.resultsrc = C_RES_ALUOUT;
        c.regw      = 1'b1;
      end
      S_BRANCH: begin
        c.alusrcb   = C_SRCB_EXT;
        c.resultsrc = C_RES_ALURESULT;
        c.pcs       = 1'b1;
        c.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_if
// Description : Controller <-> datapath bundle. The master modport is the
//               controller (consumes Instr/ALUFlags, drives the datapath
//               controls and State); the slave modport is the datapath side.
// Ports       : Instr[31:12], ALUFlags{N,Z,C,V}; write enables PCWrite,
//               MemWrite, RegWrite, IRWrite; mux selects AdrSrc, ALUSrcA,
//               ALUSrcB, ResultSrc, RegSrc, ImmSrc; ALUControl; State.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_controller_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         MemWrite;
  logic         RegWrite;
  logic         IRWrite;
  logic         AdrSrc;
  logic         ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ResultSrc;
  logic [1:0]   RegSrc;
  logic [1:0]   ImmSrc;
  logic [2:0]   ALUControl;
  logic [3:0]   State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, RegSrc, ImmSrc, ALUControl, State
  );
endinterface
`default_nettype wire

// File: rtl/mc_controller_mainfsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_mainfsm
// Description : Main sequencing FSM of the multicycle controller. Holds the
//               state register and a registered copy of the unconditioned
//               control word for the current state.
// Ports       : clk, reset (sync, active-high); op_i, funct5_i (immediate
//               select), funct0_i (S / load bit); state_o, ctrl_o.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_mainfsm
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op_i,
  input  logic       funct5_i,
  input  logic       funct0_i,
  output state_e     state_o,
  output ctrl_t      ctrl_o
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          2'b00:   state_d = funct5_i ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = funct0_i ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // The control word is registered alongside the state, so it always
  // matches the decode of the state currently held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  assign state_o = state_q;
  assign ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Multicycle ARM-subset controller. Wraps the main FSM with
//               the ALU decoder, condition evaluation, NZCV flag registers
//               and the conditional gating of the datapath write enables.
// Ports       : clk, reset (sync, active-high); bus (mc_controller_if
//               master modport: Instr/ALUFlags in, datapath controls out).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.master  bus
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       w_unused_rn;

  assign cond        = bus.Instr[31:28];
  assign op          = bus.Instr[27:26];
  assign funct       = bus.Instr[25:20];
  assign rd          = bus.Instr[15:12];
  assign w_unused_rn = ^bus.Instr[19:16];

  state_e state;
  ctrl_t  ctrl;

  mc_mainfsm u_mainfsm (
    .clk      (clk),
    .reset    (reset),
    .op_i     (op),
    .funct5_i (funct[5]),
    .funct0_i (funct[0]),
    .state_o  (state),
    .ctrl_o   (ctrl)
  );

  // ALU decoder; unsupported commands fall back to ADD and never write back
  logic [2:0] alu_dec;
  logic       dp_valid;

  always_comb begin
    alu_dec  = C_ALU_ADD;
    dp_valid = 1'b1;
    case (funct[4:1])
      C_CMD_ADD: alu_dec = C_ALU_ADD;
      C_CMD_SUB: alu_dec = C_ALU_SUB;
      C_CMD_AND: alu_dec = C_ALU_AND;
      C_CMD_ORR: alu_dec = C_ALU_ORR;
      C_CMD_EOR: alu_dec = C_ALU_EOR;
      default:   dp_valid = 1'b0;
    endcase
  end

  logic in_exec;
  logic in_aluwb;

  assign in_exec  = (state == S_EXECUTER) || (state == S_EXECUTEI);
  assign in_aluwb = (state == S_ALUWB);

  // Condition evaluation against the registered flags {N,Z,C,V}
  logic [3:0] flags_q;
  logic       condex_q;
  logic       condex;
  logic       fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    condex = 1'b0;
    case (cond)
      C_COND_EQ: condex = fz;
      C_COND_NE: condex = ~fz;
      C_COND_CS: condex = fc;
      C_COND_CC: condex = ~fc;
      C_COND_MI: condex = fn;
      C_COND_PL: condex = ~fn;
      C_COND_VS: condex = fv;
      C_COND_VC: condex = ~fv;
      C_COND_HI: condex = fc & ~fz;
      C_COND_LS: condex = ~fc | fz;
      C_COND_GE: condex = (fn == fv);
      C_COND_LT: condex = (fn != fv);
      C_COND_GT: condex = ~fz & (fn == fv);
      C_COND_LE: condex = fz | (fn != fv);
      C_COND_AL: condex = 1'b1;
      default:   condex = 1'b0;
    endcase
  end

  // CondEx is captured once at the end of DECODE so later flag changes
  // cannot alter the fate of the instruction already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      if (state == S_DECODE) begin
        condex_q <= condex;
      end
      if (in_exec && funct[0] && condex_q) begin
        flags_q[3:2] <= bus.ALUFlags[3:2];
        if ((alu_dec == C_ALU_ADD) || (alu_dec == C_ALU_SUB)) begin
          flags_q[1:0] <= bus.ALUFlags[1:0];
        end
      end
    end
  end

  logic regw_raw;
  logic pcs_raw;

  assign regw_raw = ctrl.regw & ~(in_aluwb & ~dp_valid);
  // A data-processing write to R15 is a PC write; a branch always is
  assign pcs_raw  = ctrl.pcs | ctrl.branch | (regw_raw & in_aluwb & (rd == 4'hF));

  assign bus.PCWrite    = ctrl.nextpc | (pcs_raw & condex_q);
  assign bus.MemWrite   = ctrl.memw & condex_q;
  assign bus.RegWrite   = regw_raw & condex_q;
  assign bus.IRWrite    = ctrl.irwrite;
  assign bus.AdrSrc     = ctrl.adrsrc;
  assign bus.ALUSrcA    = ctrl.alusrca;
  assign bus.ALUSrcB    = ctrl.alusrcb;
  assign bus.ResultSrc  = ctrl.resultsrc;
  assign bus.ALUControl = in_exec ? alu_dec : C_ALU_ADD;
  assign bus.State      = state;

  always_comb begin
    bus.RegSrc = 2'b00;
    bus.ImmSrc = 2'b00;
    case (op)
      2'b01: begin
        bus.RegSrc = {~funct[0], 1'b0};
        bus.ImmSrc = 2'b01;
      end
      2'b10: begin
        bus.RegSrc = 2'b01;
        bus.ImmSrc = 2'b10;
      end
      default: begin
        bus.RegSrc = 2'b00;
        bus.ImmSrc = 2'b00;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Self-checking bench for mc_controller: directed instruction
//               table, hand-written reset/branch sequences and randomized
//               instruction stream against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] m_flags;

  mc_controller_if bus_if ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  af;
    int          len;
    logic [19:0] states;
    logic [4:0]  regw;
    logic [4:0]  memw;
    logic [4:0]  pcw;
    logic [3:0]  flags;
  } tv_t;

  tv_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // State path of an instruction as nibbles, cycle 0 in the low nibble
  function automatic logic [19:0] path_of(input logic [31:0] ins);
    case (ins[27:26])
      2'b01:   return ins[20] ? 20'h43210 : 20'h05210;
      2'b00:   return ins[25] ? 20'h08710 : 20'h08610;
      2'b10:   return 20'h00910;
      default: return 20'h00010;
    endcase
  endfunction

  function automatic int len_of(input logic [31:0] ins);
    case (ins[27:26])
      2'b01:   return ins[20] ? 5 : 4;
      2'b00:   return 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit cmd_valid(input logic [3:0] cmd);
    return cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001};
  endfunction

  function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0010: return 3'b001;
      4'b0000: return 3'b010;
      4'b1100: return 3'b011;
      4'b0001: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Expected output vector for instruction ins while in state st
  function automatic logic [20:0] exp_vec(input int st, input logic [31:0] ins, input bit cx);
    logic pcw, memw, regw, irw, adr, asa;
    logic [1:0] asb, rs, rsrc, isrc;
    logic [2:0] alc;
    logic [3:0] cmd;
    bit valid;
    cmd = ins[24:21];
    valid = cmd_valid(cmd);
    {pcw, memw, regw, irw, adr, asa} = '0;
    asb = 2'b00; rs = 2'b00; alc = 3'b000;
    case (st)
      0: begin irw = 1; pcw = 1; asa = 1; asb = 2'b10; rs = 2'b10; end
      1: begin asa = 1; asb = 2'b10; rs = 2'b10; end
      2: asb = 2'b01;
      3: adr = 1;
      4: begin rs = 2'b01; regw = cx; end
      5: begin adr = 1; memw = cx; end
      6: alc = cmd_alu(cmd);
      7: begin asb = 2'b01; alc = cmd_alu(cmd); end
      8: begin regw = valid && cx; pcw = valid && cx && (ins[15:12] == 4'hF); end
      9: begin asb = 2'b01; rs = 2'b10; pcw = cx; end
      default: ;
    endcase
    case (ins[27:26])
      2'b01:   begin rsrc = {~ins[20], 1'b0}; isrc = 2'b01; end
      2'b10:   begin rsrc = 2'b01; isrc = 2'b10; end
      default: begin rsrc = 2'b00; isrc = 2'b00; end
    endcase
    return {4'(st), pcw, memw, regw, irw, adr, asa, asb, rs, rsrc, isrc, alc};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {bus_if.State, bus_if.PCWrite, bus_if.MemWrite, bus_if.RegWrite, bus_if.IRWrite,
            bus_if.AdrSrc, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ResultSrc,
            bus_if.RegSrc, bus_if.ImmSrc, bus_if.ALUControl};
  endfunction

  // Runs one instruction from FETCH; called at posedge+1, returns at posedge+1
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input bit rnd,
                           output logic [19:0] sts, output logic [4:0] rw,
                           output logic [4:0] mw, output logic [4:0] pw);
    logic [19:0] p;
    int n, st;
    bit cx;
    p = path_of(ins);
    n = len_of(ins);
    cx = cond_ok(ins[31:28], m_flags);
    sts = '0; rw = '0; mw = '0; pw = '0;
    for (int k = 0; k < n; k++) begin
      st = int'(p[4*k +: 4]);
      bus_if.Instr    = ins[31:12];
      bus_if.ALUFlags = rnd ? 4'($urandom) : af;
      #4;
      check($sformatf("outputs ins=%h st=%0d", ins, st), 32'(dut_vec()), 32'(exp_vec(st, ins, cx)));
      sts[4*k +: 4] = bus_if.State;
      rw[k] = bus_if.RegWrite;
      mw[k] = bus_if.MemWrite;
      pw[k] = bus_if.PCWrite;
      if ((st == 6 || st == 7) && ins[20] && cx) begin
        m_flags[3:2] = bus_if.ALUFlags[3:2];
        if (ins[24:21] == 4'b0100 || ins[24:21] == 4'b0010) m_flags[1:0] = bus_if.ALUFlags[1:0];
      end
      @(posedge clk);
      #1;
    end
    check($sformatf("flags after ins=%h", ins), 32'(dut.flags_q), 32'(m_flags));
  endtask

  initial begin
    logic [19:0] sts;
    logic [4:0]  rw, mw, pw;
    logic [31:0] ins;
    logic [3:0]  cmd;
    checks  = 0;
    errors  = 0;
    m_flags = 4'h0;

    tbl[0]  = '{32'hE5910000, 4'h0, 5, 20'h43210, 5'b10000, 5'b00000, 5'b00001, 4'h0};
    tbl[1]  = '{32'hE2110000, 4'hB, 4, 20'h08710, 5'b01000, 5'b00000, 5'b00001, 4'h8};
    tbl[2]  = '{32'hE2500000, 4'h4, 4, 20'h08710, 5'b01000, 5'b00000, 5'b00001, 4'h4};
    tbl[3]  = '{32'h0A000000, 4'h0, 3, 20'h00910, 5'b00000, 5'b00000, 5'b00101, 4'h4};
    tbl[4]  = '{32'h15800000, 4'h0, 4, 20'h05210, 5'b00000, 5'b00000, 5'b00001, 4'h4};
    tbl[5]  = '{32'hE5800000, 4'h0, 4, 20'h05210, 5'b00000, 5'b01000, 5'b00001, 4'h4};
    tbl[6]  = '{32'hEC000000, 4'h0, 2, 20'h00010, 5'b00000, 5'b00000, 5'b00001, 4'h4};
    tbl[7]  = '{32'hE080F000, 4'hF, 4, 20'h08610, 5'b01000, 5'b00000, 5'b01001, 4'h4};
    tbl[8]  = '{32'h1A000000, 4'h0, 3, 20'h00910, 5'b00000, 5'b00000, 5'b00001, 4'h4};
    tbl[9]  = '{32'hE1900000, 4'hA, 4, 20'h08610, 5'b01000, 5'b00000, 5'b00001, 4'h8};
    tbl[10] = '{32'hE1400000, 4'hF, 4, 20'h08610, 5'b00000, 5'b00000, 5'b00001, 4'h8};
    tbl[11] = '{32'h4A000000, 4'h0, 3, 20'h00910, 5'b00000, 5'b00000, 5'b00101, 4'h8};

    // Reset: outputs decode FETCH while reset is held
    reset = 1'b1;
    bus_if.Instr    = '0;
    bus_if.ALUFlags = '0;
    @(posedge clk);
    #1;
    #4;
    check("reset outputs", 32'(dut_vec()), 32'(exp_vec(0, 32'h0, 1'b0)));
    check("reset flags", 32'(dut.flags_q), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed table, applied in order so flags carry between entries
    foreach (tbl[i]) begin
      run_instr(tbl[i].ins, tbl[i].af, 1'b0, sts, rw, mw, pw);
      check($sformatf("tbl%0d states", i), 32'(sts), 32'(tbl[i].states));
      check($sformatf("tbl%0d regwrite", i), 32'(rw), 32'(tbl[i].regw));
      check($sformatf("tbl%0d memwrite", i), 32'(mw), 32'(tbl[i].memw));
      check($sformatf("tbl%0d pcwrite", i), 32'(pw), 32'(tbl[i].pcw));
      check($sformatf("tbl%0d flags", i), 32'(dut.flags_q), 32'(tbl[i].flags));
    end

    // Reset asserted while an LDR sits in MEMREAD
    bus_if.Instr    = 20'hE5910;
    bus_if.ALUFlags = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("midreset pre state", 32'(bus_if.State), 32'd3);
    reset = 1'b1;
    #4;
    check("midreset pre regwrite", 32'(bus_if.RegWrite), 32'd0);
    @(posedge clk);
    #1;
    #4;
    check("midreset state", 32'(bus_if.State), 32'd0);
    check("midreset flags", 32'(dut.flags_q), 32'h0);
    check("midreset outputs", 32'(dut_vec()), 32'(exp_vec(0, 32'hE5910000, 1'b0)));
    @(posedge clk);
    #1;
    reset   = 1'b0;
    m_flags = 4'h0;

    // BEQ with Z=0 walks the branch path but only FETCH writes the PC
    run_instr(32'h0A000000, 4'h0, 1'b0, sts, rw, mw, pw);
    check("beq notaken states", 32'(sts), 32'h00910);
    check("beq notaken pcwrite", 32'(pw), 32'b00001);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      ins = $urandom;
      ins[27:26] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) ins[31:28] = 4'hE;
      if (ins[27:26] == 2'b00) begin
        case ($urandom_range(0, 5))
          0: cmd = 4'b0100;
          1: cmd = 4'b0010;
          2: cmd = 4'b0000;
          3: cmd = 4'b1100;
          4: cmd = 4'b0001;
          default: cmd = 4'b1101;
        endcase
        ins[24:21] = cmd;
        if (!cmd_valid(cmd)) ins[20] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      run_instr(ins, 4'h0, 1'b1, sts, rw, mw, pw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
